// File: rtl/serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_digit.sv
// Combinational DIGIT-bit ripple adder used for one step of the serial datapath.
module serial_digit_add #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per clock, registered valid/ready on both sides,
// carry-out and signed overflow reported with the result.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_addsub: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_addsub: DIGIT must be positive and divide WIDTH");
    end

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             a_msb_reg, a_msb_next;
    logic             beff_msb_reg, beff_msb_next;
    logic             in_ready_reg, in_ready_next;
    logic             out_valid_reg, out_valid_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic [WIDTH-1:0] sum_shift;

    serial_digit_add #(.DIGIT(DIGIT)) u_digit (
        .a    (sum_reg[DIGIT-1:0]),
        .b    (b_reg[DIGIT-1:0]),
        .cin  (carry_reg),
        .s    (dig_s),
        .cout (dig_cout)
    );

    // The result digit enters at the top so that after N steps the word is in place.
    if (DIGIT == WIDTH) begin : g_shift_full
        assign sum_shift = dig_s;
    end else begin : g_shift_part
        assign sum_shift = {dig_s, sum_reg[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_next     = state_reg;
        sum_next       = sum_reg;
        b_next         = b_reg;
        carry_next     = carry_reg;
        cnt_next       = cnt_reg;
        a_msb_next     = a_msb_reg;
        beff_msb_next  = beff_msb_reg;
        in_ready_next  = in_ready_reg;
        out_valid_next = out_valid_reg;
        cout_next      = cout_reg;
        ovf_next       = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    sum_next      = in_a;
                    b_next        = in_sub ? ~in_b : in_b;
                    carry_next    = in_sub;
                    a_msb_next    = in_a[WIDTH-1];
                    beff_msb_next = in_b[WIDTH-1] ^ in_sub;
                    cnt_next      = '0;
                    in_ready_next = 1'b0;
                    state_next    = RUN;
                end
            end
            RUN: begin
                sum_next   = sum_shift;
                b_next     = b_reg >> DIGIT;
                carry_next = dig_cout;
                cnt_next   = cnt_reg + CW'(1);
                if (cnt_reg == CW'(N - 1)) begin
                    state_next     = DONE;
                    out_valid_next = 1'b1;
                    cout_next      = dig_cout;
                    ovf_next       = (a_msb_reg == beff_msb_reg) && (dig_s[DIGIT-1] != a_msb_reg);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    in_ready_next  = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sum_reg       <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            a_msb_reg     <= 1'b0;
            beff_msb_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sum_reg       <= sum_next;
            b_reg         <= b_next;
            carry_reg     <= carry_next;
            cnt_reg       <= cnt_next;
            a_msb_reg     <= a_msb_next;
            beff_msb_reg  <= beff_msb_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
            cout_reg      <= cout_next;
            ovf_reg       <= ovf_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
    assign out_ovf   = ovf_reg;

    // Full-width reference result captured at accept, used only by the properties below.
    logic [WIDTH-1:0] golden_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            golden_reg <= '0;
        end else if (state_reg == IDLE && in_valid && in_ready_reg) begin
            golden_reg <= in_sub ? (in_a - in_b) : (in_a + in_b);
        end
    end

    a_in_stable: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_a) && $stable(in_b) && $stable(in_sub)));

    a_result: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_sum == golden_reg));

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_sum) && $stable(out_cout) && $stable(out_ovf)));

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed cases on (8,1) and (8,4), then randomized traffic
// with random backpressure on every WIDTH/DIGIT combination against an arithmetic model.
module tb_serial_addsub;

    localparam int NCFG = 8;

    function automatic int w_of(input int k);
        return (k < 4) ? 8 : 16;
    endfunction

    function automatic int d_of(input int k);
        return ((k % 4) == 3) ? w_of(k) : (1 << (k % 4));
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_s    [NCFG];
    logic [15:0] b_s    [NCFG];
    logic        sub_s  [NCFG];
    logic        iv_s   [NCFG];
    logic        ordy_s [NCFG];
    logic        ir_s   [NCFG];
    logic        ov_s   [NCFG];
    logic        co_s   [NCFG];
    logic        of_s   [NCFG];
    logic [15:0] sum_s  [NCFG];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        localparam int W = w_of(gi);
        localparam int D = d_of(gi);
        logic [W-1:0] sw;
        logic ir, ov, co, ofl;

        serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv_s[gi]),
            .in_ready  (ir),
            .in_a      (a_s[gi][W-1:0]),
            .in_b      (b_s[gi][W-1:0]),
            .in_sub    (sub_s[gi]),
            .out_valid (ov),
            .out_ready (ordy_s[gi]),
            .out_sum   (sw),
            .out_cout  (co),
            .out_ovf   (ofl)
        );

        assign ir_s[gi]  = ir;
        assign ov_s[gi]  = ov;
        assign co_s[gi]  = co;
        assign of_s[gi]  = ofl;
        assign sum_s[gi] = 16'(sw);
    end

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ofl;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   acc_n;
    int   done_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int w, input longint a, input longint b, input bit sub,
                         output exp_t e);
        longint m, r, sa, sb, sr;
        m  = longint'(1) << w;
        r  = sub ? (a - b + m) : (a + b);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sr = sub ? (sa - sb) : (sa + sb);
        e.sum = 16'(r % m);
        e.co  = sub ? (a >= b) : (r >= m);
        e.ofl = (sr < -(m / 2)) || (sr >= m / 2);
    endtask

    task automatic do_op(input int k, input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] e_sum, input logic e_co, input logic e_of);
        int cyc;
        cyc = 0;
        while (!ir_s[k] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ready_before_op", 32'(ir_s[k]), 32'd1);
        a_s[k] = a; b_s[k] = b; sub_s[k] = sub; iv_s[k] = 1'b1;
        @(posedge clk); #1;
        iv_s[k] = 1'b0;
        cyc = 0;
        while (!ov_s[k] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(w_of(k) / d_of(k)));
        chk("sum", 32'(sum_s[k]), 32'(e_sum));
        chk("cout", 32'(co_s[k]), 32'(e_co));
        chk("ovf", 32'(of_s[k]), 32'(e_of));
        chk("busy_in_ready", 32'(ir_s[k]), 32'd0);
        $display("op cfg=%0d a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d",
                 k, a, b, sub, sum_s[k], co_s[k], of_s[k]);
        ordy_s[k] = 1'b1;
        @(posedge clk); #1;
        ordy_s[k] = 1'b0;
        chk("release_out_valid", 32'(ov_s[k]), 32'd0);
        chk("release_in_ready", 32'(ir_s[k]), 32'd1);
    endtask

    // One cycle of random traffic; gen=0 stops issuing new operations (drain).
    task automatic rand_step(input int k, input bit gen, inout exp_t pend);
        bit acc, dn;
        logic [15:0] mask, sum_o;
        logic co_o, of_o;
        exp_t e;
        mask = 16'((32'd1 << w_of(k)) - 1);
        if (gen && !iv_s[k] && ($urandom % 4 != 0)) begin
            a_s[k]   = 16'($urandom) & mask;
            b_s[k]   = 16'($urandom) & mask;
            sub_s[k] = 1'($urandom);
            model(w_of(k), longint'(a_s[k]), longint'(b_s[k]), sub_s[k], pend);
            iv_s[k]  = 1'b1;
        end
        ordy_s[k] = gen ? ($urandom % 3 != 0) : 1'b1;
        acc   = iv_s[k] && ir_s[k];
        dn    = ov_s[k] && ordy_s[k];
        sum_o = sum_s[k]; co_o = co_s[k]; of_o = of_s[k];
        @(posedge clk); #1;
        if (acc) begin
            exp_q.push_back(pend);
            acc_n++;
            iv_s[k] = 1'b0;
        end
        if (dn) begin
            done_n++;
            chk("rand_result_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rand_sum", 32'(sum_o), 32'(e.sum));
                chk("rand_cout", 32'(co_o), 32'(e.co));
                chk("rand_ovf", 32'(of_o), 32'(e.ofl));
                $display("op cfg=%0d W=%0d D=%0d -> sum=%h cout=%0d ovf=%0d",
                         k, w_of(k), d_of(k), sum_o, co_o, of_o);
            end
        end
    endtask

    initial begin
        exp_t pend;
        int   cyc;
        for (int k = 0; k < NCFG; k++) begin
            a_s[k] = '0; b_s[k] = '0; sub_s[k] = 1'b0; iv_s[k] = 1'b0; ordy_s[k] = 1'b0;
        end
        pend = '{sum: 16'h0, co: 1'b0, ofl: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir_s[0]), 32'd1);
        chk("rst_out_valid", 32'(ov_s[0]), 32'd0);
        chk("rst_out_sum", 32'(sum_s[0]), 32'd0);
        chk("rst_out_cout", 32'(co_s[0]), 32'd0);
        chk("rst_out_ovf", 32'(of_s[0]), 32'd0);
        rst = 1'b0;

        // WIDTH=8, DIGIT=1
        do_op(0, 16'h3C, 16'h25, 1'b0, 16'h61, 1'b0, 1'b0);
        do_op(0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1);
        do_op(0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1);
        // WIDTH=8, DIGIT=4
        do_op(2, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0);
        do_op(2, 16'h00, 16'h01, 1'b1, 16'hFF, 1'b0, 1'b0);

        // Backpressure: result held while new operands wait upstream.
        a_s[0] = 16'h12; b_s[0] = 16'h34; sub_s[0] = 1'b0; iv_s[0] = 1'b1;
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        cyc = 0;
        while (!ov_s[0] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_valid", 32'(ov_s[0]), 32'd1);
        a_s[0] = 16'h50; b_s[0] = 16'h0F; sub_s[0] = 1'b1; iv_s[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_sum", 32'(sum_s[0]), 32'h46);
            chk("bp_hold_cout", 32'(co_s[0]), 32'd0);
            chk("bp_hold_valid", 32'(ov_s[0]), 32'd1);
            chk("bp_in_ready", 32'(ir_s[0]), 32'd0);
        end
        ordy_s[0] = 1'b1;
        @(posedge clk); #1;
        ordy_s[0] = 1'b0;
        chk("bp_release_valid", 32'(ov_s[0]), 32'd0);
        chk("bp_release_ready", 32'(ir_s[0]), 32'd1);
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        chk("bp_accept_next", 32'(ir_s[0]), 32'd0);
        cyc = 0;
        while (!ov_s[0] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_second_sum", 32'(sum_s[0]), 32'h41);
        chk("bp_second_cout", 32'(co_s[0]), 32'd1);
        chk("bp_second_ovf", 32'(of_s[0]), 32'd0);
        ordy_s[0] = 1'b1;
        @(posedge clk); #1;
        ordy_s[0] = 1'b0;

        // Reset during RUN discards the operation.
        a_s[0] = 16'hAA; b_s[0] = 16'h55; sub_s[0] = 1'b0; iv_s[0] = 1'b1;
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", 32'(ir_s[0]), 32'd1);
        chk("abort_out_valid", 32'(ov_s[0]), 32'd0);
        chk("abort_out_sum", 32'(sum_s[0]), 32'd0);
        do_op(0, 16'h10, 16'h20, 1'b0, 16'h30, 1'b0, 1'b0);

        // Random traffic with random backpressure on every configuration.
        for (int k = 0; k < NCFG; k++) begin
            exp_q.delete();
            acc_n  = 0;
            done_n = 0;
            for (int c = 0; c < 400; c++) rand_step(k, 1'b1, pend);
            cyc = 0;
            while ((iv_s[k] || exp_q.size() > 0) && cyc < 200) begin
                rand_step(k, 1'b0, pend);
                cyc++;
            end
            ordy_s[k] = 1'b0;
            chk("rand_drained", 32'(exp_q.size()), 32'd0);
            chk("rand_acc_eq_done", 32'(acc_n), 32'(done_n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
